imem_loader: RTL and testbench

//  Instruction-memory responder on the core fetch port: returns the word at the core's PC, combinationally.

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: instruction-memory responder for the core fetch port, with a
// byte-serial loader that lets an external host write a program image.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pc_i             fetch byte address from the core
//   inst_o           instruction at pc_i (combinational), NOP when out of range or loading
//   core_hold_o      1 while the loader owns the array; the core must stall fetch
//   load_start_i     pulse: begin (or restart) an image load at word 0
//   load_valid_i     load_byte_i valid this cycle
//   load_byte_i      image byte, little-endian within each word
//   load_ready_o     loader accepts a byte
//   load_end_i       pulse: image complete
//   load_done_o      pulse: final word committed, back to serving fetches
//   load_err_o       sticky: image exceeded DEPTH words; cleared by load_start_i
module imem_loader #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic        core_hold_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  output logic        load_ready_o,
  input  logic        load_end_i,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  // waddr is one bit wider than the array index so it can sit at DEPTH
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneW   = (AW+1)'(1);

  logic [1:0]  state_q, state_d;
  logic [AW:0] waddr_q, waddr_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] wbuf_q, wbuf_d;   // lanes 0..2; lane 3 comes straight from the input
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    bidx_d    = bidx_q;
    wbuf_d    = wbuf_q;
    err_d     = err_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr_q[AW-1:0];
    mem_wdata = '0;

    case (state_q)
      StIdle: begin
        if (load_start_i) begin
          state_d = StLoad;
          waddr_d = '0;
          bidx_d  = '0;
          wbuf_d  = '0;
          err_d   = 1'b0;
        end
      end

      StLoad: begin
        if (load_start_i) begin
          // Restart: the partial word and any byte offered this cycle are discarded
          waddr_d = '0;
          bidx_d  = '0;
          wbuf_d  = '0;
          err_d   = 1'b0;
        end else begin
          if (load_valid_i) begin
            if (bidx_q == 2'd3) begin
              mem_wdata = {load_byte_i, wbuf_q};
              if (waddr_q < DepthW) begin
                mem_we  = 1'b1;
                waddr_d = waddr_q + OneW;
              end else begin
                err_d = 1'b1;
              end
              wbuf_d = '0;
            end else begin
              case (bidx_q)
                2'd0:    wbuf_d[7:0]   = load_byte_i;
                2'd1:    wbuf_d[15:8]  = load_byte_i;
                default: wbuf_d[23:16] = load_byte_i;
              endcase
            end
            bidx_d = bidx_q + 2'd1;
          end
          if (load_end_i) begin
            state_d = StCommit;
          end
        end
      end

      StCommit: begin
        // Unfilled upper lanes of wbuf are already zero
        if (bidx_q != 2'd0) begin
          mem_wdata = {8'h00, wbuf_q};
          if (waddr_q < DepthW) begin
            mem_we  = 1'b1;
            waddr_d = waddr_q + OneW;
          end else begin
            err_d = 1'b1;
          end
        end
        bidx_d  = '0;
        wbuf_d  = '0;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      waddr_q <= '0;
      bidx_q  <= '0;
      wbuf_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      bidx_q  <= bidx_d;
      wbuf_q  <= wbuf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Array is deliberately not reset so the image survives a core reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [AW-1:0] rd_idx;
  logic          rd_in_range;
  logic          unused_pc_lsb;

  assign rd_idx        = pc_i[AW+1:2];
  assign rd_in_range   = (pc_i[31:AW+2] == '0) && ({1'b0, rd_idx} < DepthW);
  assign unused_pc_lsb = ^pc_i[1:0];

  always_comb begin
    inst_o = NOP_INST;
    if (state_q == StIdle && rd_in_range) begin
      inst_o = mem[rd_idx];
    end
  end

  assign load_ready_o = (state_q == StLoad);
  assign core_hold_o  = (state_q != StIdle);
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        start, valid, ld_end;
  logic [7:0]  ld_byte;

  logic [31:0] inst, inst4;
  logic        hold, hold4, ready, ready4, done, done4, err, err4;

  int done_cnt  = 0;
  int done_cnt4 = 0;
  int checks    = 0;
  int errors    = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .inst_o(inst), .core_hold_o(hold),
    .load_start_i(start), .load_valid_i(valid), .load_byte_i(ld_byte),
    .load_ready_o(ready), .load_end_i(ld_end), .load_done_o(done), .load_err_o(err)
  );

  imem_loader #(.DEPTH(4), .AW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .inst_o(inst4), .core_hold_o(hold4),
    .load_start_i(start), .load_valid_i(valid), .load_byte_i(ld_byte),
    .load_ready_o(ready4), .load_end_i(ld_end), .load_done_o(done4), .load_err_o(err4)
  );

  always @(posedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done4) done_cnt4 <= done_cnt4 + 1;
  end

  // Scoreboard: sel 0..5 observe the 1024-word instance, sel 8..13 the 4-word one
  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] exp;
  } chk_t;

  chk_t  exp_q[$];
  string name_q[$];

  function automatic logic [31:0] actual(input logic [3:0] sel);
    case (sel)
      4'd0:  return inst;
      4'd1:  return {31'd0, hold};
      4'd2:  return {31'd0, ready};
      4'd3:  return {31'd0, err};
      4'd4:  return {31'd0, done};
      4'd5:  return done_cnt;
      4'd8:  return inst4;
      4'd9:  return {31'd0, hold4};
      4'd10: return {31'd0, ready4};
      4'd11: return {31'd0, err4};
      4'd12: return {31'd0, done4};
      4'd13: return done_cnt4;
      default: return 32'hdead_beef;
    endcase
  endfunction

  initial begin
    chk_t        c;
    string       n;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        n = name_q.pop_front();
        a = actual(c.sel);
        checks++;
        if (a !== c.exp) begin
          errors++;
          $display("FAIL %s (sel %0d): got %h expected %h", n, c.sel, a, c.exp);
        end
      end
    end
  end

  task automatic expect_one(input logic [3:0] sel, input logic [31:0] exp, input string name);
    exp_q.push_back('{sel: sel, exp: exp});
    name_q.push_back(name);
  endtask

  task automatic expect_both(input logic [3:0] sel, input logic [31:0] exp, input string name);
    expect_one(sel, exp, name);
    expect_one(sel + 4'd8, exp, {name, "_d4"});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_end);
    valid   = 1'b1;
    ld_byte = b;
    ld_end  = with_end;
    tick();
    valid  = 1'b0;
    ld_end = 1'b0;
  endtask

  // Ends the load, checks the single COMMIT cycle and the done pulse after it
  task automatic finish_load(input logic end_with_byte, input logic [7:0] b, input string name);
    if (end_with_byte) send_byte(b, 1'b1);
    else begin
      ld_end = 1'b1;
      tick();
      ld_end = 1'b0;
    end
    expect_both(4'd1, 32'd1, {name, "_commit_hold"});
    expect_both(4'd2, 32'd0, {name, "_commit_ready"});
    expect_both(4'd4, 32'd0, {name, "_commit_done"});
    tick();
    expect_both(4'd4, 32'd1, {name, "_done_pulse"});
    expect_both(4'd1, 32'd0, {name, "_idle_hold"});
    tick();
    expect_both(4'd4, 32'd0, {name, "_done_low"});
  endtask

  task automatic read_both(input logic [31:0] addr, input logic [31:0] exp, input string name);
    pc = addr;
    expect_both(4'd0, exp, name);
    tick();
  endtask

  initial begin
    logic [7:0] img1 [8];
    logic [7:0] img2 [6];
    img1 = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

    rst_n = 1'b0; pc = '0; start = 1'b0; valid = 1'b0; ld_end = 1'b0; ld_byte = '0;
    tick();
    tick();
    expect_both(4'd1, 32'd0, "rst_hold");
    expect_both(4'd2, 32'd0, "rst_ready");
    expect_both(4'd3, 32'd0, "rst_err");
    expect_both(4'd4, 32'd0, "rst_done");
    tick();
    rst_n = 1'b1;
    tick();

    // Two-word image, fetch of word 1 in the first IDLE cycle
    pc = 32'h4;
    do_start();
    expect_both(4'd0, Nop, "load_inst_nop");
    expect_both(4'd1, 32'd1, "load_hold");
    expect_both(4'd2, 32'd1, "load_ready");
    foreach (img1[i]) send_byte(img1[i], 1'b0);
    finish_load(1'b0, 8'h00, "t1");
    read_both(32'h0, 32'h00100513, "t1_w0");
    read_both(32'h4, 32'h00200593, "t1_w1");
    expect_both(4'd5, 32'd1, "t1_done_cnt");

    // Partial trailing word is zero-filled
    do_start();
    foreach (img2[i]) send_byte(img2[i], 1'b0);
    finish_load(1'b0, 8'h00, "t2");
    read_both(32'h0, 32'hDDCCBBAA, "t2_w0");
    read_both(32'h7, 32'h00002211, "t2_w1_lsb_ignored");

    // Out-of-range fetch
    read_both(32'h0000_1000, Nop, "t3_oob");
    pc = 32'h10;
    expect_one(4'd8, Nop, "t3_oob_d4");
    tick();

    // End coincident with the 4th byte: word written, no partial write on top of word 1
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    finish_load(1'b1, 8'h04, "t5");
    read_both(32'h0, 32'h04030201, "t5_w0");
    read_both(32'h4, 32'h00002211, "t5_w1_kept");
    expect_both(4'd5, 32'd3, "t5_done_cnt");

    // 20-byte image: overflows the 4-word instance only
    do_start();
    for (int k = 0; k < 20; k++) begin
      send_byte(8'h30 + 8'(k), 1'b0);
      if (k == 15) expect_one(4'd11, 32'd0, "t4_err_before_ovf_d4");
    end
    expect_one(4'd11, 32'd1, "t4_err_d4");
    expect_one(4'd10, 32'd1, "t4_ready_after_ovf_d4");
    expect_one(4'd3, 32'd0, "t4_err_big");
    tick();
    finish_load(1'b0, 8'h00, "t4");
    read_both(32'h0, 32'h33323130, "t4_w0");
    read_both(32'h4, 32'h37363534, "t4_w1");
    read_both(32'h8, 32'h3B3A3938, "t4_w2");
    read_both(32'hC, 32'h3F3E3D3C, "t4_w3");
    pc = 32'h10;
    expect_one(4'd0, 32'h43424140, "t4_w4_big");
    expect_one(4'd8, Nop, "t4_w4_d4");
    expect_one(4'd11, 32'd1, "t4_err_sticky_d4");
    tick();
    expect_both(4'd5, 32'd4, "t4_done_cnt");

    // Restart clears the error; then reset mid-word-2
    do_start();
    expect_both(4'd3, 32'd0, "t6_err_cleared");
    for (int k = 0; k < 11; k++) send_byte(8'h50 + 8'(k), 1'b0);
    #1;
    rst_n = 1'b0;
    pc = 32'h8;
    expect_both(4'd1, 32'd0, "t6_rst_hold");
    expect_both(4'd2, 32'd0, "t6_rst_ready");
    expect_both(4'd0, 32'h3B3A3938, "t6_w2_untouched");
    tick();
    rst_n = 1'b1;
    tick();
    expect_both(4'd4, 32'd0, "t6_no_done");
    tick();
    read_both(32'h0, 32'h53525150, "t6_w0");
    read_both(32'h4, 32'h57565554, "t6_w1");
    expect_both(4'd5, 32'd4, "t6_done_cnt");
    tick();
    tick();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
